// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the integer core pipeline control.
//   state_t : sequencing FSM state (RUN / MEM_WAIT / ERR, 2 bits)
//   REG_AW  : register address width
//   X0      : hard-wired zero register address
package core_pkg;
  localparam int REG_AW = 5;
  localparam logic [4:0] X0 = 5'd0;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that holds at all-ones instead of wrapping.
//   CLK   : clock
//   clear : synchronous clear, wins over inc
//   inc   : count enable
//   cnt   : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge CLK)
    cnt <= clear ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline enable/flush/bubble sequencing for the 5-stage core.
//   CLK, RST         : clock, synchronous active-high reset
//   id_*             : source registers read by the instruction in ID
//   ex_*             : load / destination info of the instruction in EX, branch resolution
//   mem_req/ready    : data-memory handshake of the instruction in MEM
//   pc_en .. memwb_bubble : per-stage pipeline register controls (combinational)
//   state_o          : FSM state, stall_cnt/flush_cnt : saturating perf counters
//   mem_timeout_err  : sticky flag, set when a memory wait exceeds MEM_TIMEOUT
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_wreg_en,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_bubble,
  output logic              exmem_en,
  output logic              memwb_bubble,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              mem_timeout_err
);
  import core_pkg::*;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic          lu_haz, mem_stall, timeout, freeze, normal;
  assign lu_haz = ex_load && ex_wreg_en && ex_wreg != REG_AW'(X0) &&
                  ((id_use_rs1 && id_rs1 == ex_wreg) || (id_use_rs2 && id_rs2 == ex_wreg));
  assign mem_stall = mem_req && !mem_ready;
  assign timeout   = wait_cnt == WW'(MEM_TIMEOUT);
  always_ff @(posedge CLK)
    state <= RST ? RUN : state_nx;
  always_comb
    state_nx = state == RUN      ? (mem_stall ? MEM_WAIT : RUN) :
               state == MEM_WAIT ? (mem_ready ? RUN : timeout ? ERR : MEM_WAIT) :
               state == ERR      ? ERR : RUN;
  // Freeze covers the cycle that discovers the stall, every unfinished wait
  // cycle and the terminal error state; a ready cycle in MEM_WAIT runs normally
  // so a branch held in EX during the wait is acted on then.
  always_comb begin
    freeze       = state == ERR || (state == RUN && mem_stall) || (state == MEM_WAIT && !mem_ready);
    normal       = !RST && !freeze;
    pc_en        = normal && (ex_branch_taken || !lu_haz);
    ifid_en      = normal && (ex_branch_taken || !lu_haz);
    ifid_flush   = normal && ex_branch_taken;
    idex_en      = normal;
    idex_bubble  = normal && (ex_branch_taken || lu_haz);
    exmem_en     = normal;
    memwb_bubble = !RST && freeze;
  end
  always_ff @(posedge CLK) begin
    wait_cnt <= RST ? '0 :
                state == RUN ? (mem_stall ? WW'(1) : '0) :
                state == MEM_WAIT ? (mem_ready ? '0 : timeout ? wait_cnt : wait_cnt + 1'b1) :
                wait_cnt;
    mem_timeout_err <= !RST && (mem_timeout_err || (state == MEM_WAIT && !mem_ready && timeout));
  end
  assign state_o = state;
  sat_counter #(.W(CNT_W)) u_stall (
    .CLK   (CLK),
    .clear (RST),
    .inc   (!pc_en),
    .cnt   (stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .CLK   (CLK),
    .clear (RST),
    .inc   (ifid_flush),
    .cnt   (flush_cnt)
  );
endmodule
